// File: rtl/stopwatch_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_counter: 100 Hz timebase, start/pause/clear control and        |
// | cascaded BCD MM:SS.CC counter with lap strobe and wrap pulse.            |
// | Optional button filter enabled by defining DEBOUNCE_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stopwatch_counter #(
  parameter int CLK_DIV   = 500000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d7,
  output logic [3:0] d8,
  output logic       running,
  output logic       lap_strb,
  output logic       ovf
);

  localparam int              c_PW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_PW-1:0] c_PMAX  = c_PW'(CLK_DIV - 1);
  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_RUN   = 2'd1;
  localparam logic [1:0]      c_PAUSE = 2'd2;

  // Elaborates to nothing for legal parameter values.
  generate
    if (CLK_DIV < 2 || DB_CYCLES < 1) begin : g_param_guard
    end
  endgenerate

  logic [1:0] w_btn;  // {lap, ss} levels feeding the edge detector

`ifdef DEBOUNCE_EN
  localparam int              c_DW   = $clog2(DB_CYCLES + 1);
  localparam logic [c_DW-1:0] c_DMAX = c_DW'(DB_CYCLES - 1);
  logic [1:0] w_raw;
  assign w_raw = {btn_lap, btn_ss};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_db
      logic [c_DW-1:0] r_cnt;
      logic            r_lvl;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (w_raw[g] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DMAX) begin
          r_lvl <= w_raw[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_btn[g] = r_lvl;
    end
  endgenerate
`else
  assign w_btn = {btn_lap, btn_ss};
`endif

  logic [1:0] r_btn_q;
  logic       w_ss_rise;
  logic       w_lap_rise;

  always_ff @(posedge clk) begin
    if (!rst) r_btn_q <= 2'b00;
    else      r_btn_q <= w_btn;
  end

  assign w_ss_rise  = w_btn[0] & ~r_btn_q[0];
  assign w_lap_rise = w_btn[1] & ~r_btn_q[1];

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_run;
  logic       w_clear;
  logic       w_lap;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Start/stop takes priority over lap whenever both rise together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_ss_rise) w_state_nxt = c_RUN;
      c_RUN:   if (w_ss_rise) w_state_nxt = c_PAUSE;
      c_PAUSE: begin
        if (w_ss_rise)       w_state_nxt = c_RUN;
        else if (w_lap_rise) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_run   = (r_state == c_RUN);
    w_clear = (r_state == c_PAUSE) && !w_ss_rise && w_lap_rise;
    w_lap   = (r_state == c_RUN)   && !w_ss_rise && w_lap_rise;
  end

  assign running = w_run;

  logic [c_PW-1:0] r_pre;
  logic            r_lap_strb;
  logic            r_ovf;
  logic            w_at_max;
  logic            w_tick;

  assign w_at_max = (r_pre == c_PMAX);
  // A tick due during the strobe cycle waits with the prescaler parked at max.
  assign w_tick   = w_run && w_at_max && !r_lap_strb;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (r_state == c_IDLE || w_clear) begin
      r_pre <= '0;
    end else if (w_run) begin
      if (!w_at_max)        r_pre <= r_pre + 1'b1;
      else if (!r_lap_strb) r_pre <= '0;
    end
  end

  function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

  logic [3:0] r_d1, r_d2, r_d4, r_d5, r_d7, r_d8;
  logic       w_c7, w_c5, w_c4, w_c2, w_c1, w_wrap;

  assign w_c7   = w_tick && (r_d8 >= 4'd9);
  assign w_c5   = w_c7   && (r_d7 >= 4'd9);
  assign w_c4   = w_c5   && (r_d5 >= 4'd9);
  assign w_c2   = w_c4   && (r_d4 >= 4'd5);
  assign w_c1   = w_c2   && (r_d2 >= 4'd9);
  assign w_wrap = w_c1   && (r_d1 >= 4'd5);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d1       <= 4'd0;
      r_d2       <= 4'd0;
      r_d4       <= 4'd0;
      r_d5       <= 4'd0;
      r_d7       <= 4'd0;
      r_d8       <= 4'd0;
      r_ovf      <= 1'b0;
      r_lap_strb <= 1'b0;
    end else begin
      r_ovf      <= w_wrap;
      r_lap_strb <= w_lap;
      if (w_clear) begin
        r_d1 <= 4'd0;
        r_d2 <= 4'd0;
        r_d4 <= 4'd0;
        r_d5 <= 4'd0;
        r_d7 <= 4'd0;
        r_d8 <= 4'd0;
      end else begin
        if (w_tick) r_d8 <= bcd_next(r_d8, 4'd9);
        if (w_c7)   r_d7 <= bcd_next(r_d7, 4'd9);
        if (w_c5)   r_d5 <= bcd_next(r_d5, 4'd9);
        if (w_c4)   r_d4 <= bcd_next(r_d4, 4'd5);
        if (w_c2)   r_d2 <= bcd_next(r_d2, 4'd9);
        if (w_c1)   r_d1 <= bcd_next(r_d1, 4'd5);
      end
    end
  end

  assign d1       = r_d1;
  assign d2       = r_d2;
  assign d4       = r_d4;
  assign d5       = r_d5;
  assign d7       = r_d7;
  assign d8       = r_d8;
  assign lap_strb = r_lap_strb;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// Testbench for stopwatch_counter: vector table, corner sequences and a
// randomized run against a centisecond-count reference model.
module tb_stopwatch_counter;

  localparam int CLK_DIV = 4;
  localparam int DB      = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] d1, d2, d4, d5, d7, d8;
  logic       running, lap_strb, ovf;

  stopwatch_counter #(.CLK_DIV(CLK_DIV), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .d1(d1), .d2(d2), .d4(d4), .d5(d5), .d7(d7), .d8(d8),
    .running(running), .lap_strb(lap_strb), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [26:0] w_dut;
  assign w_dut = {d1, d2, d4, d5, d7, d8, running, lap_strb, ovf};

  int n_tests = 0;
  int n_fail  = 0;
  bit use_model = 1'b1;

  // Reference model: elapsed time as a plain centisecond count.
  int m_mode = 0;  // 0 idle, 1 run, 2 pause
  int m_cs   = 0;
  int m_frac = 0;
  bit m_strb = 1'b0;
  bit m_ovf  = 1'b0;
  bit m_ssq  = 1'b0;
  bit m_lapq = 1'b0;

  function automatic logic [23:0] digs(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [26:0] model_vec();
    return {digs(m_cs), (m_mode == 1), m_strb, m_ovf};
  endfunction

  task automatic model_step(input logic s, input logic l, input logic r);
    bit sr, lr;
    if (!r) begin
      m_mode = 0; m_cs = 0; m_frac = 0; m_strb = 0; m_ovf = 0; m_ssq = 0; m_lapq = 0;
    end else begin
      sr = s && !m_ssq;
      lr = l && !m_lapq;
      m_ssq  = s;
      m_lapq = l;
      m_ovf  = 1'b0;
      if (m_mode == 1) begin
        if (m_frac < CLK_DIV - 1) m_frac++;
        else if (!m_strb) begin
          m_frac = 0;
          m_cs   = (m_cs + 1) % 360000;
          m_ovf  = (m_cs == 0);
        end
      end
      m_strb = 1'b0;
      if (sr) m_mode = (m_mode == 1) ? 2 : 1;
      else if (lr && m_mode == 1) m_strb = 1'b1;
      else if (lr && m_mode == 2) begin
        m_mode = 0; m_cs = 0; m_frac = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic l, input logic r);
    @(negedge clk);
    btn_ss  = s;
    btn_lap = l;
    rst     = r;
    @(posedge clk);
    model_step(s, l, r);
    #1;
    if (use_model) chk("model", w_dut, model_vec());
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct packed {
    logic        r;
    logic        s;
    logic        l;
    logic [23:0] dig;
    logic        run;
    logic        strb;
    logic        ov;
  } vec_t;

  vec_t tbl [19];

  initial begin
`ifdef DEBOUNCE_EN
    use_model = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    idle_steps(6);
    chk("db_glitch", {26'd0, running}, 27'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    chk("db_latency", {26'd0, running}, 27'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("db_press", {26'd0, running}, 27'd1);
    idle_steps(20);
    chk("db_held", {26'd0, running}, 27'd1);
`else
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].s, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d", i), w_dut, {tbl[i].dig, tbl[i].run, tbl[i].strb, tbl[i].ov});
    end

    // 100 ticks, then pause and hold
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    idle_steps(400);
    chk("run400", w_dut, {24'h000100, 1'b1, 1'b0, 1'b0});
    step(1'b1, 1'b0, 1'b1);
    chk("pause", w_dut, {24'h000100, 1'b0, 1'b0, 1'b0});
    idle_steps(200);
    chk("hold200", w_dut, {24'h000100, 1'b0, 1'b0, 1'b0});

    // Wrap from 59:59.98, preloaded while idle
    do_reset();
    dut.r_d1 = 4'd5; dut.r_d2 = 4'd9; dut.r_d4 = 4'd5;
    dut.r_d5 = 4'd9; dut.r_d7 = 4'd9; dut.r_d8 = 4'd8;
    m_cs = 359998;
    step(1'b1, 1'b0, 1'b1);
    idle_steps(4);
    chk("pre_wrap", w_dut, {24'h595999, 1'b1, 1'b0, 1'b0});
    idle_steps(4);
    chk("wrap", w_dut, {24'h000000, 1'b1, 1'b0, 1'b1});
    idle_steps(1);
    chk("ovf_pulse", w_dut, {24'h000000, 1'b1, 1'b0, 1'b0});

    // Lap at 00:00.37 with the next tick landing in the strobe cycle
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    idle_steps(150);
    step(1'b0, 1'b1, 1'b1);
    chk("lap_strb", w_dut, {24'h000037, 1'b1, 1'b1, 1'b0});
    idle_steps(1);
    chk("lap_frozen", w_dut, {24'h000037, 1'b1, 1'b0, 1'b0});
    idle_steps(1);
    chk("lap_deferred", w_dut, {24'h000038, 1'b1, 1'b0, 1'b0});

    // Pause/clear and simultaneous buttons from pause
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    idle_steps(20);
    step(1'b1, 1'b0, 1'b1);
    chk("p_pause", w_dut, {24'h000005, 1'b0, 1'b0, 1'b0});
    step(1'b0, 1'b1, 1'b1);
    chk("p_clear", w_dut, {24'h000000, 1'b0, 1'b0, 1'b0});
    idle_steps(1);
    step(1'b1, 1'b0, 1'b1);
    idle_steps(10);
    step(1'b1, 1'b0, 1'b1);
    idle_steps(1);
    step(1'b1, 1'b1, 1'b1);
    chk("p_both", w_dut, {24'h000002, 1'b1, 1'b0, 1'b0});
    idle_steps(1);
    chk("p_frac", w_dut, {24'h000003, 1'b1, 1'b0, 1'b0});

    // Randomized buttons and occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 499) != 0));
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
